// File: rtl/ebpc_pkg.sv
// rtl/ebpc_pkg.sv - shared EBPC constants, decoder op codes and the decoded block type
package ebpc_pkg;

    localparam int DATA_W        = 8;
    localparam int BLOCK_SIZE    = 8;
    localparam int MAX_SYMB_LEN  = 8;
    localparam int LOG_MAX_WORDS = 8;

    localparam int NUM_PLANES  = DATA_W + 1;
    localparam int DBX_W       = BLOCK_SIZE - 1;
    localparam int ZRLE_W      = $clog2(DATA_W);
    localparam int POS_W       = $clog2(BLOCK_SIZE);
    localparam int LEN_W       = $clog2(MAX_SYMB_LEN + 1);
    localparam int PLANE_IDX_W = $clog2(NUM_PLANES + 1);

    localparam logic [0:0] RAW_PREFIX         = 1'b1;
    localparam logic [1:0] SINGLE_ZERO_PREFIX = 2'b01;
    localparam logic [2:0] ZERO_RUN_PREFIX    = 3'b001;
    localparam logic [4:0] ALL_ONES_CODE      = 5'b00000;
    localparam logic [4:0] DBP_ZERO_CODE      = 5'b00001;
    localparam logic [4:0] TWO_ONES_CODE      = 5'b00010;

    typedef enum logic [2:0] {
        OP_RAW,
        OP_ZERO,
        OP_ZRUN,
        OP_ONES,
        OP_DBPZ,
        OP_TWO1,
        OP_ONE1
    } dec_op_t;

    typedef struct packed {
        logic                                  flush;
        logic [DATA_W-1:0]                     base;
        logic [NUM_PLANES-1:0][BLOCK_SIZE-2:0] dbp;
    } dbp_block_t;

endpackage

// File: rtl/bpc_decoder_if.sv
// rtl/bpc_decoder_if.sv - compressed stream input and decoded block output handshakes
interface bpc_decoder_if
    import ebpc_pkg::*;
#(
    parameter int IN_W = 8
);
    logic [IN_W-1:0] data_i;
    logic            valid_i;
    logic            ready_o;
    dbp_block_t      block_o;
    logic            valid_o;
    logic            ready_i;

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, block_o, valid_o
    );

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, block_o, valid_o
    );
endinterface

// File: rtl/bpc_symbol_decode.sv
// rtl/bpc_symbol_decode.sv - classifies the symbol at the head of the bit buffer
module bpc_symbol_decode
    import ebpc_pkg::*;
(
    input  logic [MAX_SYMB_LEN-1:0] symb,
    output dec_op_t                 op,
    output logic [DBX_W-1:0]        dbx,
    output logic [PLANE_IDX_W-1:0]  run,
    output logic [LEN_W-1:0]        len,
    output logic                    bad_pos
);
    logic [ZRLE_W-1:0] zrle;
    logic [POS_W-1:0]  pos;

    assign zrle = symb[MAX_SYMB_LEN-4 -: ZRLE_W];
    assign pos  = symb[MAX_SYMB_LEN-6 -: POS_W];

    // Prefix match from shortest to longest; the 5-bit codes share a 000 head.
    always_comb begin
        op      = OP_ONE1;
        dbx     = '0;
        run     = PLANE_IDX_W'(1);
        len     = LEN_W'(MAX_SYMB_LEN);
        bad_pos = 1'b0;
        if (symb[MAX_SYMB_LEN-1 -: 1] == RAW_PREFIX) begin
            op  = OP_RAW;
            dbx = symb[MAX_SYMB_LEN-2 -: DBX_W];
        end else if (symb[MAX_SYMB_LEN-1 -: 2] == SINGLE_ZERO_PREFIX) begin
            op  = OP_ZERO;
            len = LEN_W'(2);
        end else if (symb[MAX_SYMB_LEN-1 -: 3] == ZERO_RUN_PREFIX) begin
            op  = OP_ZRUN;
            len = LEN_W'(3 + ZRLE_W);
            run = PLANE_IDX_W'(zrle) + PLANE_IDX_W'(2);
        end else begin
            case (symb[MAX_SYMB_LEN-1 -: 5])
                ALL_ONES_CODE: begin
                    op  = OP_ONES;
                    len = LEN_W'(5);
                    dbx = '1;
                end
                DBP_ZERO_CODE: begin
                    op  = OP_DBPZ;
                    len = LEN_W'(5);
                end
                TWO_ONES_CODE: begin
                    op = OP_TWO1;
                    if (pos >= POS_W'(BLOCK_SIZE - 2)) begin
                        dbx     = DBX_W'(1) << pos;
                        bad_pos = 1'b1;
                    end else begin
                        dbx = DBX_W'(3) << pos;
                    end
                end
                default: begin
                    op  = OP_ONE1;
                    dbx = DBX_W'(1) << pos;
                end
            endcase
        end
    end
endmodule

// File: rtl/bpc_decoder.sv
// rtl/bpc_decoder.sv - bit-plane-compression decoder producing one dbp_block_t per block
module bpc_decoder
    import ebpc_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [LOG_MAX_WORDS-1:0] num_blocks_i,
    output logic                     busy_o,
    output logic                     err_o,
    bpc_decoder_if.slave             bus
);
    localparam int BUF_W  = ((MAX_SYMB_LEN > DATA_W) ? MAX_SYMB_LEN : DATA_W) + IN_W;
    localparam int FILL_W = $clog2(BUF_W + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BASE   = 3'd1;
    localparam logic [2:0] S_PLANES = 3'd2;
    localparam logic [2:0] S_OUT    = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]               state_q;
    logic [BUF_W-1:0]         bits_q, bits_next;
    logic [FILL_W-1:0]        fill_q, fill_mid, fill_next, pop_n;
    dbp_block_t               blk_q;
    logic [DBX_W-1:0]         prev_q, plane_val;
    logic [PLANE_IDX_W-1:0]   idx_q, remaining, n_write, new_idx;
    logic [LOG_MAX_WORDS-1:0] blk_cnt_q, nblk_q;
    logic                     err_q;

    dec_op_t                  op;
    logic [DBX_W-1:0]         dbx;
    logic [PLANE_IDX_W-1:0]   run;
    logic [LEN_W-1:0]         len;
    logic                     bad_pos, over_run, base_ok, sym_ok, push, last_plane;

    bpc_symbol_decode u_symbol_decode (
        .symb    (bits_q[BUF_W-1 -: MAX_SYMB_LEN]),
        .op      (op),
        .dbx     (dbx),
        .run     (run),
        .len     (len),
        .bad_pos (bad_pos)
    );

    assign bus.ready_o = (state_q != S_IDLE) && (fill_q <= FILL_W'(BUF_W - IN_W));
    assign bus.valid_o = (state_q == S_OUT);
    assign bus.block_o = blk_q;
    assign busy_o      = (state_q != S_IDLE) || start_i;
    assign err_o       = err_q;

    // Pop from the head of the buffer first, then append any accepted word right below the survivors.
    always_comb begin
        base_ok   = (state_q == S_BASE) && (fill_q >= FILL_W'(DATA_W));
        sym_ok    = (state_q == S_PLANES) && (fill_q >= FILL_W'(len));
        push      = bus.valid_i && bus.ready_o;
        pop_n     = '0;
        if (base_ok) begin
            pop_n = FILL_W'(DATA_W);
        end else if (sym_ok) begin
            pop_n = FILL_W'(len);
        end
        fill_mid  = fill_q - pop_n;
        bits_next = bits_q << pop_n;
        fill_next = fill_mid;
        if (push) begin
            bits_next = bits_next | ({bus.data_i, {(BUF_W - IN_W){1'b0}}} >> fill_mid);
            fill_next = fill_mid + FILL_W'(IN_W);
        end
        remaining  = PLANE_IDX_W'(NUM_PLANES) - idx_q;
        over_run   = (op == OP_ZRUN) && (run > remaining);
        n_write    = over_run ? remaining : run;
        new_idx    = idx_q + n_write;
        plane_val  = (op == OP_DBPZ) ? '0 : (dbx ^ prev_q);
        last_plane = (new_idx == PLANE_IDX_W'(NUM_PLANES));
    end

    // Block sequencing, plane writes and the sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            bits_q    <= '0;
            fill_q    <= '0;
            blk_q     <= '0;
            prev_q    <= '0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            nblk_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            bits_q <= bits_next;
            fill_q <= fill_next;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q   <= S_BASE;
                        err_q     <= 1'b0;
                        blk_cnt_q <= '0;
                        idx_q     <= '0;
                        nblk_q    <= num_blocks_i;
                    end
                end
                S_BASE: begin
                    if (base_ok) begin
                        blk_q.base <= bits_q[BUF_W-1 -: DATA_W];
                        prev_q     <= '0;
                        idx_q      <= '0;
                        state_q    <= S_PLANES;
                    end
                end
                S_PLANES: begin
                    if (sym_ok) begin
                        for (int k = 0; k < NUM_PLANES; k++) begin
                            if ((PLANE_IDX_W'(k) >= idx_q) && (PLANE_IDX_W'(k) < new_idx)) begin
                                blk_q.dbp[k] <= plane_val;
                            end
                        end
                        prev_q <= plane_val;
                        idx_q  <= new_idx;
                        if (over_run || bad_pos) begin
                            err_q <= 1'b1;
                        end
                        if (last_plane) begin
                            blk_q.flush <= (blk_cnt_q == nblk_q - LOG_MAX_WORDS'(1));
                            state_q     <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.ready_i) begin
                        blk_cnt_q <= blk_cnt_q + LOG_MAX_WORDS'(1);
                        state_q   <= blk_q.flush ? S_DRAIN : S_BASE;
                    end
                end
                S_DRAIN: begin
                    bits_q  <= '0;
                    fill_q  <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bpc_decoder.sv
// tb/tb_bpc_decoder.sv - directed self-checking bench for bpc_decoder
module tb_bpc_decoder;
    import ebpc_pkg::*;

    typedef logic [NUM_PLANES-1:0][DBX_W-1:0] planes_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [LOG_MAX_WORDS-1:0] num_blocks = '0;
    logic                     busy;
    logic                     err;

    bpc_decoder_if #(.IN_W(8)) bus ();

    bpc_decoder #(.IN_W(8)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .num_blocks_i (num_blocks),
        .busy_o       (busy),
        .err_o        (err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] stim[$];
    dbp_block_t got_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic feed();
        int k = 0;
        int guard = 0;
        while (k < stim.size() && guard < 400) begin
            @(negedge clk);
            bus.data_i  = stim[k];
            bus.valid_i = 1'b1;
            if (bus.ready_o) k++;
            guard++;
        end
        @(negedge clk);
        bus.valid_i = 1'b0;
        if (k < stim.size()) check("feed_timeout", 64'(k), 64'(stim.size()));
    endtask

    task automatic collect(input int nblk, input int stall);
        int got = 0;
        int guard = 0;
        bus.ready_i = (stall == 0);
        while (got < nblk && guard < 400) begin
            @(negedge clk);
            guard++;
            if (bus.valid_o && !bus.ready_i) begin
                repeat (stall) @(negedge clk);
                check("stall_ready_low", 64'(bus.ready_o), 64'(0));
                check("stall_valid_held", 64'(bus.valid_o), 64'(1));
                bus.ready_i = 1'b1;
            end
            if (bus.valid_o && bus.ready_i) begin
                got_q.push_back(bus.block_o);
                got++;
            end
        end
        if (got < nblk) check("collect_timeout", 64'(got), 64'(nblk));
        bus.ready_i = 1'b1;
    endtask

    task automatic run(input int nblk, input int stall);
        int g = 0;
        got_q.delete();
        @(negedge clk);
        num_blocks = LOG_MAX_WORDS'(nblk);
        start = 1'b1;
        #1;
        check("busy_on_start", 64'(busy), 64'(1));
        @(negedge clk);
        start = 1'b0;
        check("err_cleared_by_start", 64'(err), 64'(0));
        fork
            feed();
            collect(nblk, stall);
        join
        while (busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("back_to_idle", 64'(busy), 64'(0));
        check("block_count", 64'(got_q.size()), 64'(nblk));
    endtask

    task automatic check_block(input string tag, input int idx, input logic flush,
                               input logic [7:0] base, input planes_t dbp);
        if (idx >= got_q.size()) begin
            check({tag, "_missing"}, 64'(0), 64'(1));
            return;
        end
        check({tag, "_flush"}, 64'(got_q[idx].flush), 64'(flush));
        check({tag, "_base"}, 64'(got_q[idx].base), 64'(base));
        for (int p = 0; p < NUM_PLANES; p++) begin
            check($sformatf("%s_dbp%0d", tag, p), 64'(got_q[idx].dbp[p]), 64'(dbp[p]));
        end
    endtask

    initial begin
        bit saw_valid;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.valid_o), 64'(0));
        check("rst_ready", 64'(bus.ready_o), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_block_zero", 64'(bus.block_o == '0), 64'(1));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 64'(bus.ready_o), 64'(0));

        stim = '{8'h10, 8'h3C};
        run(1, 0);
        check_block("zrun9", 0, 1'b1, 8'h10, '0);
        check("zrun9_err", 64'(err), 64'(0));

        stim = '{8'h00, 8'hD5, 8'h38};
        run(1, 0);
        check_block("raw55", 0, 1'b1, 8'h00, {9{7'h55}});

        stim = '{8'hFF, 8'h00, 8'h4D};
        run(1, 0);
        check_block("ones_dbpz", 0, 1'b1, 8'hFF, {{8{7'h00}}, 7'h7F});

        stim = '{8'hA5, 8'h15, 8'h1A, 8'h4C};
        run(1, 0);
        check_block("two_one", 0, 1'b1, 8'hA5, {{8{7'h64}}, 7'h60});
        check("two_one_err", 64'(err), 64'(0));

        stim = '{8'h00, 8'h16, 8'h38};
        run(1, 0);
        check_block("badpos", 0, 1'b1, 8'h00, {9{7'h40}});
        check("badpos_err", 64'(err), 64'(1));

        stim = '{8'h00, 8'h2C, 8'hF0};
        run(1, 0);
        check_block("overrun", 0, 1'b1, 8'h00, '0);
        check("overrun_err", 64'(err), 64'(1));
        repeat (5) @(negedge clk);
        check("overrun_err_sticky", 64'(err), 64'(1));

        stim = '{8'h10, 8'h3C, 8'h40, 8'hF0};
        run(2, 20);
        check_block("two_blk0", 0, 1'b0, 8'h10, '0);
        check_block("two_blk1", 1, 1'b1, 8'h10, '0);

        got_q.delete();
        @(negedge clk);
        num_blocks = LOG_MAX_WORDS'(1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stim = '{8'h00, 8'hD5};
        feed();
        repeat (3) @(negedge clk);
        check("mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(bus.valid_o), 64'(0));
        check("mid_rst_ready", 64'(bus.ready_o), 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_err", 64'(err), 64'(0));
        check("mid_rst_block_zero", 64'(bus.block_o == '0), 64'(1));
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.valid_o) saw_valid = 1'b1;
        end
        check("mid_rst_no_valid", 64'(saw_valid), 64'(0));

        stim = '{8'h10, 8'h3C};
        run(1, 0);
        check_block("after_rst", 0, 1'b1, 8'h10, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
